// File: rtl/exibe_resultado.sv
// Result display stage: captures S/Bout, converts to sign+magnitude and scans a 3-digit
// active-low 7-segment display. Optional macro ZERO_BLANK_EN blanks a zero tens digit.
module exibe_resultado #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] S,
  input  logic       Bout,
  input  logic       load,
  output logic [6:0] seg,
  output logic [2:0] dig,
  output logic       valid,
  output logic       done
);

  localparam int DATA_W = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Bout extends S into a 5-bit signed value; its absolute value wraps -16 to 0.
  function automatic logic [DATA_W-1:0] to_mag(input logic bout, input logic [DATA_W-1:0] s);
    logic signed [DATA_W:0] v;
    logic signed [DATA_W:0] a;
    v = $signed({bout, s});
    a = (v < 0) ? -v : v;
    return a[DATA_W-1:0];
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  logic [DATA_W:0]   cap_p0_q,   cap_p0_d;
  logic              vld_p0_q,   vld_p0_d;
  logic              neg_p1_q,   neg_p1_d;
  logic              tens_p1_q,  tens_p1_d;
  logic [DATA_W-1:0] units_p1_q, units_p1_d;
  logic              vld_p1_q,   vld_p1_d;
  logic              valid_q,    valid_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [1:0]        idx_q,      idx_d;
  logic [6:0]        seg_q,      seg_d;
  logic [2:0]        dig_q,      dig_d;
  logic [DATA_W-1:0] mag_p1;

  always_comb begin
    cap_p0_d   = cap_p0_q;
    vld_p0_d   = load;
    neg_p1_d   = neg_p1_q;
    tens_p1_d  = tens_p1_q;
    units_p1_d = units_p1_q;
    vld_p1_d   = vld_p0_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    seg_d      = SEG_BLANK;
    dig_d      = 3'b111;
    mag_p1     = to_mag(cap_p0_q[DATA_W], cap_p0_q[DATA_W-1:0]);

    // Stage p0: capture raw result on the strobe
    if (load) cap_p0_d = {Bout, S};

    // Stage p1: sign/magnitude and decimal split into the display registers
    if (vld_p0_q) begin
      neg_p1_d   = cap_p0_q[DATA_W] && (cap_p0_q[DATA_W-1:0] != '0);
      tens_p1_d  = (mag_p1 >= 4'd10);
      units_p1_d = (mag_p1 >= 4'd10) ? mag_p1 - 4'd10 : mag_p1;
      valid_d    = 1'b1;
    end

    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    // Output stage: registered digit drive from current scan index
    if (valid_q) begin
      dig_d = ~(3'b001 << idx_q);
      case (idx_q)
        2'd0: seg_d = glyph(units_p1_q);
`ifdef ZERO_BLANK_EN
        2'd1: seg_d = tens_p1_q ? glyph(4'd1) : SEG_BLANK;
`else
        2'd1: seg_d = tens_p1_q ? glyph(4'd1) : glyph(4'd0);
`endif
        2'd2: seg_d = neg_p1_q ? SEG_MINUS : SEG_BLANK;
        default: seg_d = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_p0_q   <= '0;
      vld_p0_q   <= 1'b0;
      neg_p1_q   <= 1'b0;
      tens_p1_q  <= 1'b0;
      units_p1_q <= '0;
      vld_p1_q   <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      seg_q      <= SEG_BLANK;
      dig_q      <= 3'b111;
    end else begin
      cap_p0_q   <= cap_p0_d;
      vld_p0_q   <= vld_p0_d;
      neg_p1_q   <= neg_p1_d;
      tens_p1_q  <= tens_p1_d;
      units_p1_q <= units_p1_d;
      vld_p1_q   <= vld_p1_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg   = seg_q;
  assign dig   = dig_q;
  assign valid = valid_q;
  assign done  = vld_p1_q;

endmodule
